rca_word_sequencer: RTL and testbench

- Multi-cycle add/subtract controller for wide operands built on one 8-bit ripple-carry adder (rca).
- Each operation is split into NBYTES byte slices, issued LSB first, one slice per clock; the carry is held in a register between slices.
- Sits between the ALU control logic and the shared rca instance, so wide arithmetic needs no wider adder.

---
 rtl/rca_word_sequencer.sv | 173 +++++++++++++++++
 tb/tb_rca_word_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rca_word_sequencer.sv
// Multi-cycle wide add/subtract built on one 8-bit ripple-carry adder, one byte slice per clock.
// Optional RCA_SEQ_ZERO_EN adds a registered zero flag for the completed result.
module rca_word_sequencer #(
    parameter int NBYTES = 4,
    localparam int W = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op_sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
`ifdef RCA_SEQ_ZERO_EN
    output logic         zero,
`endif
    output logic         overflow
);

    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            sub_q, sub_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic            accept;
    logic            last_slice;
    logic [7:0]      slice_a;
    logic [7:0]      slice_b;
    logic            slice_cin;
    logic [7:0]      slice_sum;
    logic [8:0]      rc;

    // A new operation may begin in IDLE or in the DONE cycle; RUN ignores start.
    assign accept     = start && (state_q != ST_RUN);
    assign last_slice = (idx_q == LAST_IDX);

    assign slice_a   = a_q[{idx_q, 3'b000} +: 8];
    assign slice_b   = b_q[{idx_q, 3'b000} +: 8] ^ {8{sub_q}};
    assign slice_cin = (idx_q == '0) ? sub_q : carry_q;

    assign rc[0] = slice_cin;
    for (genvar gi = 0; gi < 8; gi++) begin : g_rca
        assign slice_sum[gi] = slice_a[gi] ^ slice_b[gi] ^ rc[gi];
        assign rc[gi+1]      = (slice_a[gi] & slice_b[gi]) | (rc[gi] & (slice_a[gi] ^ slice_b[gi]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (last_slice) state_d = ST_DONE;
            ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

`ifdef RCA_SEQ_ZERO_EN
    logic nz_q, nz_d;
    logic zero_q, zero_d;
`endif

    always_comb begin
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
`ifdef RCA_SEQ_ZERO_EN
        nz_d     = nz_q;
        zero_d   = zero_q;
`endif
        if (accept) begin
            a_d     = a;
            b_d     = b;
            sub_d   = op_sub;
            idx_d   = '0;
            carry_d = 1'b0;
`ifdef RCA_SEQ_ZERO_EN
            nz_d    = 1'b0;
`endif
        end else if (state_q == ST_RUN) begin
            result_d[{idx_q, 3'b000} +: 8] = slice_sum;
            carry_d = rc[8];
            idx_d   = last_slice ? '0 : idx_q + 1'b1;
`ifdef RCA_SEQ_ZERO_EN
            nz_d    = nz_q | (|slice_sum);
`endif
            if (last_slice) begin
                cout_d = rc[8];
                // Signed overflow: operands agree in sign but the result sign differs.
                ovf_d  = (a_q[W-1] == (b_q[W-1] ^ sub_q)) && (slice_sum[7] != a_q[W-1]);
`ifdef RCA_SEQ_ZERO_EN
                zero_d = ~(nz_q | (|slice_sum));
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef RCA_SEQ_ZERO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            nz_q   <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            nz_q   <= nz_d;
            zero_q <= zero_d;
        end
    end

    assign zero = zero_q;
`endif

    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_rca_word_sequencer.sv
// Directed bench for rca_word_sequencer (NBYTES=4): vector table plus multi-cycle corner sequences.
module tb_rca_word_sequencer;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
`ifdef RCA_SEQ_ZERO_EN
    logic         zero;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    rca_word_sequencer #(.NBYTES(NB)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_sub   (op_sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
`ifdef RCA_SEQ_ZERO_EN
        .zero     (zero),
`endif
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        logic         z;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    // Start in cycle 0; busy must cover cycles 1..NB and done must pulse alone in cycle NB+1.
    task automatic run_vec(input vec_t v, input int id);
        logic busy_ok;
        a = v.a; b = v.b; op_sub = v.sub; start = 1'b1;
        tick();
        start = 1'b0;
        a = '1; b = '1; op_sub = ~v.sub;
        busy_ok = 1'b1;
        for (int k = 1; k <= NB; k++) begin
            if (!(busy === 1'b1 && done === 1'b0)) busy_ok = 1'b0;
            tick();
        end
        chk($sformatf("v%0d busy_window", id), 64'(busy_ok), 64'd1);
        chk($sformatf("v%0d done_pulse", id), {62'd0, done, busy}, 64'b10);
        chk($sformatf("v%0d result", id), 64'(result), 64'(v.res));
        chk($sformatf("v%0d cout", id), 64'(cout), 64'(v.co));
        chk($sformatf("v%0d overflow", id), 64'(overflow), 64'(v.ov));
`ifdef RCA_SEQ_ZERO_EN
        chk($sformatf("v%0d zero", id), 64'(zero), 64'(v.z));
`endif
        tick();
        chk($sformatf("v%0d done_drop", id), 64'(done), 64'd0);
        chk($sformatf("v%0d result_hold", id), 64'(result), 64'(v.res));
        $display("[TB] vec %0d a=%h b=%h sub=%0d -> result=%h cout=%0d ovf=%0d",
                 id, v.a, v.b, v.sub, result, cout, overflow);
    endtask

    initial begin
        int n;
        int extra;

        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 32'h4B4B4B4B, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        tick();
        start = 1'b1;   // reset must win over a simultaneous start
        a = 32'h1; b = 32'h1;
        tick();
        tick();
        start = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_cout_ovf", {62'd0, cout, overflow}, 64'd0);
`ifdef RCA_SEQ_ZERO_EN
        chk("reset_zero", 64'(zero), 64'd0);
`endif
        rst = 1'b0;
        tick();
        chk("idle_after_reset", {62'd0, busy, done}, 64'd0);
        $display("[TB] reset state checked");

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], i);
        end

        // start held for three cycles with changing operands: only the first capture counts
        a = 32'h00000001; b = 32'h00000002; op_sub = 1'b0; start = 1'b1;
        tick();
        a = 32'h0000FFFF; b = 32'h0000FFFF; op_sub = 1'b1;
        tick();
        a = 32'h12340000; b = 32'h00005678;
        tick();
        start = 1'b0;
        wait_done(n);
        chk("held_start_latency", 64'(n), 64'd2);
        chk("held_start_result", 64'(result), 64'h3);
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        chk("held_start_no_second_op", 64'(extra), 64'd0);
        $display("[TB] held start: result=%h extra_activity=%0d", result, extra);

        // back-to-back: second start issued in the done cycle
        a = 32'h00000010; b = 32'h00000020; op_sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        chk("b2b_first_latency", 64'(n), 64'd4);
        chk("b2b_first_result", 64'(result), 64'h30);
        a = 32'h00000100; b = 32'h00000001; op_sub = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_accept_busy", {62'd0, busy, done}, 64'b10);
        wait_done(n);
        chk("b2b_second_latency", 64'(n), 64'd4);
        chk("b2b_second_result", 64'(result), 64'hFF);
        chk("b2b_second_cout", 64'(cout), 64'd1);
        $display("[TB] back-to-back: second result=%h cout=%0d", result, cout);
        tick();

        // reset in cycle 2 of a run aborts it
        a = 32'h11223344; b = 32'h01010101; op_sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        chk("abort_no_done", 64'(extra), 64'd0);
        $display("[TB] reset mid-operation: result=%h extra_activity=%0d", result, extra);
        run_vec(vecs[0], 100);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
